// File: rtl/modop_pkg.sv
// rtl/modop_pkg.sv - shared helpers for the modop modular-arithmetic library
package modop_pkg;

    localparam int MODOP_MAXW = 128;

    typedef logic [MODOP_MAXW-1:0] modop_word_t;

    // q = {qH, zeros, 1}: qH fills the top LOGQH bits and bit 0 is always set
    function automatic modop_word_t mod_q(input modop_word_t qh, input int logq, input int logqh);
        return (qh << (logq - logqh)) | modop_word_t'(1);
    endfunction

    // Pipeline depth from the per-stage register enables
    function automatic int modop_lat(input int ff_in, input int ff_sub, input int ff_out);
        return ff_in + ff_sub + ff_out;
    endfunction

endpackage

// File: rtl/modop_pipe_reg.sv
// rtl/modop_pipe_reg.sv - optional valid+data pipeline stage with a load enable
module modop_pipe_reg #(
    parameter int W  = 1,
    parameter int EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         d_valid,
    input  logic [W-1:0] d_data,
    output logic         q_valid,
    output logic [W-1:0] q_data
);

    if (EN != 0) begin : g_reg
        // Valid and data move together; a stalled pipeline simply holds both
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q_valid <= 1'b0;
                q_data  <= '0;
            end else if (load) begin
                q_valid <= d_valid;
                q_data  <= d_data;
            end
        end
    end else begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, load};
        assign q_valid     = d_valid;
        assign q_data      = d_data;
    end

endmodule

// File: rtl/modsub.sv
// rtl/modsub.sv - pipelined modular subtractor C = (A - B) mod q with valid/ready
module modsub
    import modop_pkg::*;
#(
    parameter int LOGQ   = 64,
    parameter int LOGQH  = 47,
    parameter int FF_IN  = 0,
    parameter int FF_SUB = 0,
    parameter int FF_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOGQ-1:0]  A,
    input  logic [LOGQ-1:0]  B,
    input  logic [LOGQH-1:0] qH,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOGQ-1:0]  C
);

    localparam int LAT = modop_lat(FF_IN, FF_SUB, FF_OUT);
    localparam int W1  = 2 * LOGQ + LOGQH;
    localparam int W2  = LOGQ + 1 + LOGQH;

    // Every stage advances together, so a full pipeline can push and pop in one cycle
    logic adv;
    assign adv = ~out_valid | out_ready;

    // Stage 1: operands and modulus bits
    logic             v1;
    logic [W1-1:0]    s1;
    logic [LOGQ-1:0]  a1;
    logic [LOGQ-1:0]  b1;
    logic [LOGQH-1:0] qh1;

    modop_pipe_reg #(.W(W1), .EN(FF_IN)) u_in (
        .clk     (clk),
        .rst     (rst),
        .load    (adv),
        .d_valid (in_valid),
        .d_data  ({A, B, qH}),
        .q_valid (v1),
        .q_data  (s1)
    );
    assign {a1, b1, qh1} = s1;

    // Raw difference with one extra bit; its MSB is the borrow
    logic [LOGQ:0] d1;
    always_comb begin
        d1 = {1'b0, a1} - {1'b0, b1};
    end

    // Stage 2: raw difference plus the modulus bits needed for correction
    logic             v2;
    logic [W2-1:0]    s2;
    logic [LOGQ:0]    d2;
    logic [LOGQH-1:0] qh2;

    modop_pipe_reg #(.W(W2), .EN(FF_SUB)) u_sub (
        .clk     (clk),
        .rst     (rst),
        .load    (adv),
        .d_valid (v1),
        .d_data  ({d1, qh1}),
        .q_valid (v2),
        .q_data  (s2)
    );
    assign {d2, qh2} = s2;

    // On borrow, add q once; in-range operands never need a second pass
    logic [LOGQ-1:0] q2;
    logic [LOGQ-1:0] c2;
    always_comb begin
        q2 = LOGQ'(mod_q(MODOP_MAXW'(qh2), LOGQ, LOGQH));
        c2 = d2[LOGQ] ? (d2[LOGQ-1:0] + q2) : d2[LOGQ-1:0];
    end

    // Stage 3: result
    modop_pipe_reg #(.W(LOGQ), .EN(FF_OUT)) u_out (
        .clk     (clk),
        .rst     (rst),
        .load    (adv),
        .d_valid (v2),
        .d_data  (c2),
        .q_valid (out_valid),
        .q_data  (C)
    );

    // With no registers the block is a wire, so readiness passes straight through
    assign in_ready = (LAT == 0) ? out_ready : adv;

endmodule

// File: tb/tb_modsub.sv
// tb/tb_modsub.sv - directed and streamed self-checking bench for modsub
module tb_modsub;

    localparam int LOGQ  = 64;
    localparam int LOGQH = 47;
    localparam logic [LOGQH-1:0] QH0 = 47'h400008C00000;
    localparam logic [LOGQ-1:0]  Q0  = 64'h8000118000000001;

    typedef struct {
        logic [63:0] c;
        int          cyc;
    } ent_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic [63:0] a         = '0;
    logic [63:0] b         = '0;
    logic [46:0] qh        = QH0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] c;

    logic [7:0]  sw_ir;
    logic [7:0]  sw_ov;
    logic [63:0] sw_c [8];

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   s        = 0;
    bit   chk_lat  = 1'b1;
    bit   sw_on    = 1'b0;
    ent_t exp_q[$];
    logic        hv [64];
    logic [63:0] hc [64];

    always #5 clk = ~clk;

    modsub #(.LOGQ(LOGQ), .LOGQH(LOGQH), .FF_IN(0), .FF_SUB(0), .FF_OUT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .qH        (qh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (c)
    );

    for (genvar g = 0; g < 8; g++) begin : g_sw
        modsub #(.LOGQ(LOGQ), .LOGQH(LOGQH),
                 .FF_IN((g >> 2) & 1), .FF_SUB((g >> 1) & 1), .FF_OUT(g & 1)) u_sw (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (sw_ir[g]),
            .A         (a),
            .B         (b),
            .qH        (qh),
            .out_valid (sw_ov[g]),
            .out_ready (1'b1),
            .C         (sw_c[g])
        );
    end

    function automatic int popc(input int k);
        return ((k >> 2) & 1) + ((k >> 1) & 1) + (k & 1);
    endfunction

    function automatic logic [63:0] ref_sub(input logic [63:0] x, input logic [63:0] y,
                                            input logic [46:0] h);
        logic [64:0] qq;
        logic [64:0] r;
        qq = {1'b0, h, 16'h0000, 1'b1};
        if (x >= y) r = {1'b0, x} - {1'b0, y};
        else        r = {1'b0, x} + qq - {1'b0, y};
        return r[63:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] x, input logic [63:0] y,
                         input logic [46:0] h, input logic ordy, output logic took);
        ent_t e;
        @(negedge clk);
        in_valid  = v;
        a         = x;
        b         = y;
        qh        = h;
        out_ready = ordy;
        #1;
        took = in_valid & in_ready;
        if (out_valid & out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("c_order", c, e.c);
                if (chk_lat) chk("latency", 64'(cyc - e.cyc), 64'd1);
            end
        end
        if (took) exp_q.push_back('{c: ref_sub(x, y, h), cyc: cyc});
        if (sw_on && s < 64) begin
            hv[s] = in_valid;
            hc[s] = ref_sub(a, b, qh);
            for (int k = 0; k < 8; k++) begin
                int          l;
                logic        ev;
                logic [63:0] ec;
                l  = popc(k);
                ev = (s - l >= 0) ? hv[s - l] : 1'b0;
                ec = (s - l >= 0) ? hc[s - l] : 64'd0;
                chk($sformatf("sw%0d_ready", k), 64'(sw_ir[k]), 64'd1);
                chk($sformatf("sw%0d_valid", k), 64'(sw_ov[k]), 64'(ev));
                if (ev) chk($sformatf("sw%0d_c", k), sw_c[k], ec);
            end
            s++;
        end
        cyc++;
    endtask

    task automatic single(input string tag, input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] expc);
        logic t;
        drive(1'b1, x, y, QH0, 1'b1, t);
        chk({tag, "_take"}, 64'(t), 64'd1);
        drive(1'b0, 64'd0, 64'd0, QH0, 1'b1, t);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk(tag, c, expc);
    endtask

    task automatic drain(input string tag);
        logic t;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) drive(1'b0, 64'd0, 64'd0, QH0, 1'b1, t);
        for (int i = 0; i < 4; i++) drive(1'b0, 64'd0, 64'd0, QH0, 1'b1, t);
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        t;
        logic        ordy;
        logic [46:0] h;
        logic [63:0] qv;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] held;
        int          idx;
        int          j;

        // Reset state
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_c", c, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("rst_sw%0d_valid", k), 64'(sw_ov[k]), 64'd0);
            chk($sformatf("rst_sw%0d_c", k), sw_c[k], 64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed values
        single("t1_plain", 64'h100000000000000A, 64'h0100000000000005, 64'h0F00000000000005);
        single("t2_borrow", 64'd5, 64'd7, 64'h8000117FFFFFFFFF);
        single("t2_maxcorr", 64'd0, Q0 - 64'd1, 64'd1);
        single("t2_equal", Q0 - 64'd1, Q0 - 64'd1, 64'd0);
        single("t2_zero", 64'd0, 64'd0, 64'd0);
        drain("t2");

        // Back-pressure: 8 ops with a 3-cycle stall in the middle
        chk_lat = 1'b0;
        idx = 0;
        j   = 0;
        held = '0;
        x = {$urandom, $urandom} % Q0;
        y = {$urandom, $urandom} % Q0;
        while (idx < 8 && j < 40) begin
            ordy = !(j >= 3 && j <= 5);
            drive(1'b1, x, y, QH0, ordy, t);
            if (j >= 3 && j <= 5) begin
                chk("t4_stall_in_ready", 64'(in_ready), 64'd0);
                chk("t4_stall_out_valid", 64'(out_valid), 64'd1);
                if (j == 3) held = c;
                else        chk("t4_stall_c_stable", c, held);
            end
            if (t) begin
                idx++;
                x = {$urandom, $urandom} % Q0;
                y = {$urandom, $urandom} % Q0;
            end
            j++;
        end
        chk("t4_all_taken", 64'(idx), 64'd8);
        drain("t4");
        chk_lat = 1'b1;

        // Reset with ops in flight
        drive(1'b1, 64'd100, 64'd50, QH0, 1'b1, t);
        drive(1'b1, 64'd9, 64'd3, QH0, 1'b1, t);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_c", c, 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("t5_sw%0d_valid", k), 64'(sw_ov[k]), 64'd0);
            chk($sformatf("t5_sw%0d_c", k), sw_c[k], 64'd0);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        single("t5_after", 64'd20, 64'd22, Q0 - 64'd2);
        drain("t5");

        // Streaming with varying q, swept over every register configuration
        sw_on = 1'b1;
        s     = 0;
        for (int i = 0; i < 16; i++) begin
            h  = {1'b1, 46'({$urandom, $urandom})};
            qv = {h, 16'h0000, 1'b1};
            x  = {$urandom, $urandom} % qv;
            y  = (i == 3) ? x : ({$urandom, $urandom} % qv);
            drive(1'b1, x, y, h, 1'b1, t);
            chk("t3_take", 64'(t), 64'd1);
        end
        drain("t3");
        sw_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
